// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, with a fixed WIDTH+2 cycle latency from launch to Done.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic             Flush,
  input  logic [2:0]       MulDivOp,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] MulDivResult,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  state_t           state;
  logic [CW-1:0]    counter;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             neg_q;
  logic             neg_r;
  logic             div0;
  logic             ovf;

  // Launch-time operand conditioning
  logic             a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  always_comb begin
    a_signed = (MulDivOp == OP_MULH) || (MulDivOp == OP_MULHSU) ||
               (MulDivOp == OP_DIV)  || (MulDivOp == OP_REM);
    b_signed = (MulDivOp == OP_MULH) || (MulDivOp == OP_DIV) || (MulDivOp == OP_REM);
    a_neg    = a_signed & SrcA[WIDTH-1];
    b_neg    = b_signed & SrcB[WIDTH-1];
    a_abs    = a_neg ? (~SrcA + 1'b1) : SrcA;
    b_abs    = b_neg ? (~SrcB + 1'b1) : SrcB;
  end

  // One iteration: hi/lo hold the running product, or remainder/quotient when dividing
  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_trial;
  logic           div_ok;

  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, b_mag} : '0);
    div_trial = {hi, lo[WIDTH-1]} - {1'b0, b_mag};
    div_ok    = ~div_trial[WIDTH];
  end

  // Sign correction and result selection, consumed in FIX
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quot_s, rem_s, dvd_s, fix_result;

  always_comb begin
    prod   = {hi, lo};
    prod_s = neg_q ? (~prod + 1'b1) : prod;
    quot_s = neg_q ? (~lo + 1'b1) : lo;
    rem_s  = neg_r ? (~hi + 1'b1) : hi;
    dvd_s  = neg_r ? (~a_mag + 1'b1) : a_mag;
    fix_result = '0;
    case (op_q)
      OP_MUL:                fix_result = prod_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_result = prod_s[2*WIDTH-1:WIDTH];
      3'b100, 3'b101: begin
        if (div0)     fix_result = '1;
        else if (ovf) fix_result = {1'b1, {(WIDTH-1){1'b0}}};
        else          fix_result = quot_s;
      end
      default: begin
        if (div0)     fix_result = dvd_s;
        else if (ovf) fix_result = '0;
        else          fix_result = rem_s;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      counter      <= '0;
      op_q         <= '0;
      a_mag        <= '0;
      b_mag        <= '0;
      hi           <= '0;
      lo           <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      div0         <= 1'b0;
      ovf          <= 1'b0;
      MulDivResult <= '0;
    end else if (Flush && (state != IDLE)) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (Start && !Flush) begin
            state   <= CALC;
            counter <= '0;
            op_q    <= MulDivOp;
            a_mag   <= a_abs;
            b_mag   <= b_abs;
            hi      <= '0;
            lo      <= a_abs;
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            div0    <= (SrcB == '0);
            ovf     <= ((MulDivOp == OP_DIV) || (MulDivOp == OP_REM)) &&
                       (SrcA == {1'b1, {(WIDTH-1){1'b0}}}) && (&SrcB);
          end
        end
        CALC: begin
          if (op_q[2]) begin
            if (div_ok) begin
              hi <= div_trial[WIDTH-1:0];
              lo <= {lo[WIDTH-2:0], 1'b1};
            end else begin
              hi <= {hi[WIDTH-2:0], lo[WIDTH-1]};
              lo <= {lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            {hi, lo} <= {mul_sum, lo[WIDTH-1:1]};
          end
          counter <= counter + 1'b1;
          if (counter == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          MulDivResult <= fix_result;
          state        <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy      = (state != IDLE);
  assign Done      = (state == DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M cases, abort/ignore/reset scenarios and
// random operands, all checked against a 64-bit arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam int LAT = 33;  // posedges after the Start edge until Done is seen

  logic         clk;
  logic         rst_n;
  logic         Start;
  logic         Flush;
  logic [2:0]   MulDivOp;
  logic [W-1:0] SrcA;
  logic [W-1:0] SrcB;
  logic [W-1:0] MulDivResult;
  logic         Busy;
  logic         Done;
  logic [1:0]   dbg_state;

  int compared = 0;
  int mismatched = 0;
  logic [W-1:0] last_result = '0;
  logic [W-1:0] exp_q[$];

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Flush(Flush), .MulDivOp(MulDivOp),
    .SrcA(SrcA), .SrcB(SrcB), .MulDivResult(MulDivResult), .Busy(Busy),
    .Done(Done), .dbg_state(dbg_state)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint          sa, sb, ub, p;
    longint unsigned pu;
    int              ia, ib;
    ia = a;
    ib = b;
    sa = longint'(ia);
    sb = longint'(ib);
    ub = longint'({32'b0, b});
    case (op)
      3'd0: begin pu = {32'b0, a} * {32'b0, b}; return pu[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // driver: launch at a negedge, returns at the negedge after the Start edge
  task automatic launch(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    MulDivOp = op; SrcA = a; SrcB = b; Start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
    SrcA = $urandom; SrcB = $urandom; MulDivOp = 3'($urandom_range(0, 7));
  endtask

  // waits for Done (bounded) and returns the number of posedges after launch
  task automatic wait_done(input int already, output int n, output logic got);
    n = already; got = 1'b0;
    while (n < 80 && !got) begin
      @(posedge clk); n++;
      @(negedge clk); got = Done;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    int n; logic got;
    exp_q.push_back(ref_model(op, a, b));
    launch(op, a, b);
    check({tag, "_busy"}, W'(Busy), W'(1));
    wait_done(0, n, got);
    check({tag, "_latency"}, W'(n), W'(LAT));
    last_result = exp_q.pop_front();
    check(tag, MulDivResult, last_result);
    @(negedge clk);
    check({tag, "_idle"}, W'({Busy, Done}), W'(0));
  endtask

  initial begin : stim
    int n; logic got; int dones;
    rst_n = 1'b0; Start = 1'b0; Flush = 1'b0; MulDivOp = '0; SrcA = '0; SrcB = '0;
    repeat (3) @(negedge clk);
    check("rst_result", MulDivResult, '0);
    check("rst_busy_done", W'({Busy, Done}), W'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mul_7x6", 3'd0, 32'd7, 32'd6);
    run_op("mulh_m1x2", 3'd1, 32'hFFFF_FFFF, 32'h2);
    run_op("mulhu_m1x2", 3'd3, 32'hFFFF_FFFF, 32'h2);
    run_op("mulhsu_m1x2", 3'd2, 32'hFFFF_FFFF, 32'h2);
    run_op("mul_m1xm1", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'h2);
    run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'h2);
    run_op("divu_111_11", 3'd5, 32'h111, 32'h11);
    run_op("remu_111_11", 3'd7, 32'h111, 32'h11);
    run_op("divu_by0", 3'd5, 32'h11, 32'h0);
    run_op("remu_by0", 3'd7, 32'h11, 32'h0);
    run_op("div_by0", 3'd4, 32'hFFFF_FFF9, 32'h0);
    run_op("rem_by0", 3'd6, 32'hFFFF_FFF9, 32'h0);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000);

    // Start re-pulsed mid-operation must not disturb the original op
    exp_q.push_back(ref_model(3'd4, 32'd1000, 32'hFFFF_FFF9));
    launch(3'd4, 32'd1000, 32'hFFFF_FFF9);
    repeat (3) @(negedge clk);
    MulDivOp = 3'd0; SrcA = 32'd3; SrcB = 32'd3; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    wait_done(4, n, got);
    check("restart_latency", W'(n), W'(LAT));
    last_result = exp_q.pop_front();
    check("restart_result", MulDivResult, last_result);
    @(negedge clk);

    // Flush at cycle 10: back to idle, no Done, result held
    launch(3'd0, 32'd123, 32'd456);
    repeat (9) @(negedge clk);
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    check("flush_busy", W'(Busy), W'(0));
    dones = 0;
    repeat (40) begin @(negedge clk); if (Done) dones++; end
    check("flush_no_done", W'(dones), W'(0));
    check("flush_result_held", MulDivResult, last_result);

    // Flush in idle has priority over Start
    MulDivOp = 3'd0; SrcA = 32'd2; SrcB = 32'd2; Start = 1'b1; Flush = 1'b1;
    @(negedge clk);
    Start = 1'b0; Flush = 1'b0;
    check("flush_idle_start", W'(Busy), W'(0));

    // Reset at cycle 20 of a DIV
    launch(3'd4, 32'hDEAD_BEEF, 32'd77);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", W'({MulDivResult, Busy, Done}), W'(0));
    check("midrst_result", MulDivResult, '0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (40) begin @(negedge clk); if (Done) dones++; end
    check("midrst_no_done", W'(dones), W'(0));
    last_result = '0;

    // random operands, back-to-back issue
    for (int i = 0; i < 40; i++) begin
      run_op("rand", 3'($urandom_range(0, 7)), rand_val(), rand_val());
    end

    check("scoreboard_empty", W'(exp_q.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit for the RV32M extension.
- Sits in the execute stage beside the ALU. It consumes the same SrcA/SrcB operands from the operand-select mux and feeds the execute result mux alongside ALUResult.
- The controller holds the instruction in execute while Busy is high and selects MulDivResult on Done.
- Fixed, operand-independent latency keeps stall logic simple.

Parameters:
- WIDTH, 32, operand/result width. Iteration count equals WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- Start  input  1  launch an operation; sampled only in IDLE
- Flush  input  1  synchronous abort of the operation in progress
- MulDivOp  input  3  RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcA  input  WIDTH  rs1 operand (multiplicand/dividend)
- SrcB  input  WIDTH  rs2 operand (multiplier/divisor)
- MulDivResult  output  WIDTH  registered result; holds until the next Done
- Busy  output  1  high whenever state != IDLE
- Done  output  1  one-cycle pulse; MulDivResult is valid in the same cycle

Behaviour:
- Reset: clk and reset ports are clk and rst_n. Reset is asynchronous and active-low, with one clock domain.
- While rst_n=0: state=IDLE; MulDivResult=0, Busy=0, Done=0; counter and internal accumulators=0.
- Reset asserted mid-operation discards the operation immediately. No Done is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE -> CALC on an edge with Start=1 and Flush=0.
  - Capture MulDivOp, magnitudes of SrcA/SrcB (signed per op), result-sign flags, divide-by-zero and overflow flags.
  - Counter=0.
- CALC: one iteration per cycle. Counter increments; after WIDTH iterations (counter = WIDTH-1 at the edge) -> FIX.
  - Multiply: shift-add on unsigned magnitudes into a 2*WIDTH product. MULH/MULHSU treat operands as signed, SrcA only for MULHSU.
  - Divide: restoring division on magnitudes. DIV/REM are signed; DIVU/REMU are unsigned.
- FIX: one cycle; registers MulDivResult.
  - Two's-complement sign correction: quotient negated if the operand signs differ; remainder takes the dividend sign.
  - Selects the low word (MUL) or high word (MULH*), quotient (DIV*) or remainder (REM*).
  - Then -> DONE.
- DONE: Done=1 for exactly this cycle, then -> IDLE.
- Latency: Start sampled at edge E0 gives Done high in the cycle after edge E0+WIDTH+1, i.e. 34 cycles for WIDTH=32, for every op.
- Busy rises after E0 and falls after the DONE cycle.
- Special cases are resolved in FIX, at the same latency:
  - Divisor=0: DIV/DIVU -> all ones; REM/REMU -> dividend.
  - DIV of 0x80000000 by 0xFFFFFFFF -> 0x80000000; the matching REM -> 0.
- Start while Busy=1 is ignored. Operands are captured only at launch, so SrcA/SrcB may change freely afterwards.
- Flush=1 in any non-IDLE state -> IDLE at the next edge.
  - No Done; MulDivResult keeps its previous value.
  - Flush has priority over Start. Flush in IDLE has no effect, and Start in the same cycle is then ignored.
- Back-to-back: Start may be asserted in the cycle after Done; the minimum issue interval is WIDTH+3 cycles.

Test Plan:
- Reset, then MUL SrcA=7, SrcB=6, Start pulse -> Busy=1 next cycle; Done exactly 34 cycles after the Start edge; MulDivResult=0x0000002A.
- MULH with 0xFFFFFFFF×0x00000002 -> 0xFFFFFFFF. MULHU with the same operands -> 0x00000001. MULHSU with the same operands -> 0xFFFFFFFF. MUL 0xFFFFFFFF×0xFFFFFFFF -> 0x00000001.
- Signed divide of -7 by 2 -> DIV 0xFFFFFFFD (-3), REM 0xFFFFFFFF (-1). DIVU 0x00000111 by 0x00000011 -> 0x00000010, and REMU of the same -> 0x00000001.
- Divide-by-zero and overflow cases:
  - DIVU 0x11/0 -> 0xFFFFFFFF; REMU 0x11/0 -> 0x00000011.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
  - All at 34-cycle latency.
- Start re-pulsed with new operands at cycle 5 of an operation -> ignored; the original result is delivered.
- Flush at cycle 10 -> Busy=0 next cycle, no Done, MulDivResult unchanged.
- rst_n driven low at cycle 20 of a DIV -> outputs 0 immediately, no Done after release.
